// File: rtl/encoder_pkg.sv
// Shared constants and types for the event encoder and its priority encoder.
package encoder_pkg;

   localparam int unsigned N = 8;
   localparam int unsigned W = 3;

   typedef logic [W-1:0] code_t;

   function automatic logic [N-1:0] code_to_mask(input code_t c);
      logic [N-1:0] m;
      m    = '0;
      m[c] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/prio_enc8_3.sv
// Combinational 8-to-3 priority encoder: code of the highest set bit plus an any flag,
// written as plain and/or/not terms.
module prio_enc8_3
   import encoder_pkg::*;
(
   input  logic [N-1:0] i_vec,
   output code_t        o_code,
   output logic         o_any
);

   logic w_hi_any;
   logic w_lo_any;
   logic w_n6;
   logic w_n5;
   logic w_n4;
   logic w_n2;
   logic w_b1_lo;
   logic w_b0_t1;
   logic w_b0_t2;
   logic w_b0_t3;

   assign w_n6 = ~i_vec[6];
   assign w_n5 = ~i_vec[5];
   assign w_n4 = ~i_vec[4];
   assign w_n2 = ~i_vec[2];

   assign w_hi_any = i_vec[7] | i_vec[6] | i_vec[5] | i_vec[4];
   assign w_lo_any = i_vec[3] | i_vec[2] | i_vec[1] | i_vec[0];

   // Lower-priority terms are masked by every higher line that would change the bit.
   assign w_b1_lo = w_n5 & w_n4 & (i_vec[3] | i_vec[2]);
   assign w_b0_t1 = w_n6 & i_vec[5];
   assign w_b0_t2 = w_n6 & w_n4 & i_vec[3];
   assign w_b0_t3 = w_n6 & w_n4 & w_n2 & i_vec[1];

   assign o_code[2] = w_hi_any;
   assign o_code[1] = i_vec[7] | i_vec[6] | w_b1_lo;
   assign o_code[0] = i_vec[7] | w_b0_t1 | w_b0_t2 | w_b0_t3;
   assign o_any     = w_hi_any | w_lo_any;

endmodule

// File: rtl/event_encoder8_3.sv
// Collects request lines into a pending set and streams them out highest index first.
// Define EVENT_ENCODER_EDGE_DETECT_EN for rising-edge capture; default is level capture.
module event_encoder8_3
   import encoder_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_req,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_code,
   output logic         o_drop
);

   logic [N-1:0] r_pending;
   logic         r_valid;
   code_t        r_code;
   logic         r_drop;

   logic [N-1:0] w_capture;
   logic [N-1:0] w_load_mask;
   code_t        w_sel_code;
   logic         w_sel_any;
   logic         w_can_load;
   logic         w_load;
   logic         w_drop_hit;

`ifdef EVENT_ENCODER_EDGE_DETECT_EN
   logic [N-1:0] r_req_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_d <= '0;
      end else begin
         r_req_d <= i_req;
      end
   end

   assign w_capture = i_req & ~r_req_d;
`else
   assign w_capture = i_req;
`endif

   prio_enc8_3 u_prio (
      .i_vec  (r_pending),
      .o_code (w_sel_code),
      .o_any  (w_sel_any)
   );

   // Output register accepts a new code when empty or when the current one is taken.
   assign w_can_load  = ~r_valid | i_ready;
   assign w_load      = w_can_load & w_sel_any;
   assign w_load_mask = w_load ? code_to_mask(w_sel_code) : '0;
   assign w_drop_hit  = |(w_capture & r_pending & ~w_load_mask);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
         r_valid   <= 1'b0;
         r_code    <= '0;
         r_drop    <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_load_mask) | w_capture;
         r_drop    <= w_drop_hit;
         if (w_can_load) begin
            r_valid <= w_sel_any;
         end
         if (w_load) begin
            r_code <= w_sel_code;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_code  = r_code;
   assign o_drop  = r_drop;

endmodule

// File: tb/tb_event_encoder8_3.sv
// Scoreboard bench for event_encoder8_3: directed test-plan cases plus random traffic.
module tb_event_encoder8_3;
   import encoder_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] i_req;
   logic         i_ready;
   logic         o_valid;
   logic [W-1:0] o_code;
   logic         o_drop;

   event_encoder8_3 dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .i_ready (i_ready),
      .o_valid (o_valid),
      .o_code  (o_code),
      .o_drop  (o_drop)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic valid;
      logic drop;
   } cyc_t;

   cyc_t cyc_q[$];
   int   code_q[$];
   int   xfer_log[$];
   int   drop_cnt = 0;

   // Reference model: a set of pending line numbers and one output slot.
   bit m_pend[N];
   bit m_prev[N];
   bit m_valid;
   int m_code;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         foreach (m_pend[i]) begin
            m_pend[i] = 1'b0;
            m_prev[i] = 1'b0;
         end
         m_valid = 1'b0;
         m_code  = 0;
         cyc_q.delete();
         code_q.delete();
      end else begin
         bit cap[N];
         bit dropped;
         int taken;
         foreach (cap[i]) begin
`ifdef EVENT_ENCODER_EDGE_DETECT_EN
            cap[i] = i_req[i] && !m_prev[i];
`else
            cap[i] = i_req[i];
`endif
            m_prev[i] = i_req[i];
         end
         taken = -1;
         if (!m_valid || i_ready) begin
            for (int i = N - 1; i >= 0; i--) begin
               if (m_pend[i] && taken < 0) taken = i;
            end
            m_valid = (taken >= 0);
            if (taken >= 0) begin
               m_code = taken;
               code_q.push_back(taken);
            end
         end
         dropped = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (cap[i] && m_pend[i] && i != taken) dropped = 1'b1;
            if (i == taken) m_pend[i] = 1'b0;
            if (cap[i]) m_pend[i] = 1'b1;
         end
         cyc_q.push_back('{valid: m_valid, drop: dropped});
      end
   end

   cyc_t mon_e;
   always @(negedge clk) begin
      if (!rst) begin
         if (o_drop === 1'b1) drop_cnt++;
         if (o_valid === 1'b1 && i_ready) xfer_log.push_back(int'(o_code));
         if (cyc_q.size() > 0) begin
            mon_e = cyc_q.pop_front();
            check("valid", o_valid, mon_e.valid);
            check("drop", o_drop, mon_e.drop);
            if (mon_e.valid && o_valid === 1'b1) begin
               check("code_q_nonempty", code_q.size() != 0, 1);
               if (code_q.size() != 0) begin
                  check("code", o_code, code_q[0]);
                  if (i_ready) void'(code_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      rst     = 1'b0;
      i_req   = '0;
      i_ready = 1'b0;

      // Reset with all lines requesting
      #2;
      rst   = 1'b1;
      i_req = 8'hFF;
      #1;
      check("rst_valid", o_valid, 0);
      check("rst_code", o_code, 0);
      check("rst_drop", o_drop, 0);
      step(2);
      i_req = '0;
      rst   = 1'b0;
      step(3);
      check("post_rst_valid", o_valid, 0);

      // Single event
      i_ready = 1'b1;
      i_req   = 8'h20;
      step(1);
      i_req = '0;
      check("single_lat1", o_valid, 0);
      step(1);
      check("single_valid", o_valid, 1);
      check("single_code", o_code, 5);
      step(1);
      check("single_gone", o_valid, 0);

      // Priority drain
      xfer_log.delete();
      i_req = 8'h85;
      step(1);
      i_req = '0;
      step(4);
      check("drain_count", xfer_log.size(), 3);
      if (xfer_log.size() == 3) begin
         check("drain_0", xfer_log[0], 7);
         check("drain_1", xfer_log[1], 2);
         check("drain_2", xfer_log[2], 0);
      end
      check("drain_empty", o_valid, 0);

      // Backpressure
      i_ready = 1'b0;
      i_req   = 8'h0A;
      step(1);
      i_req = '0;
      step(1);
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", o_valid, 1);
         check("bp_code", o_code, 3);
         step(1);
      end
      xfer_log.delete();
      i_ready = 1'b1;
      step(3);
      check("bp_count", xfer_log.size(), 2);
      if (xfer_log.size() == 2) begin
         check("bp_0", xfer_log[0], 3);
         check("bp_1", xfer_log[1], 1);
      end

      // Drop: a line held in o_code is not pending, a second re-capture is
      i_ready  = 1'b0;
      drop_cnt = 0;
      i_req    = 8'h01;
      step(1);
      i_req = '0;
      step(2);
      check("drop_held_code", o_code, 0);
      i_req = 8'h01;
      step(1);
      i_req = '0;
      step(2);
      check("drop_none", drop_cnt, 0);
      i_req = 8'h01;
      step(1);
      i_req = '0;
      step(3);
      check("drop_one", drop_cnt, 1);
      i_ready = 1'b1;
      step(4);
      check("drop_drained", o_valid, 0);

      // Reset mid-operation
      i_ready = 1'b0;
      i_req   = 8'hF0;
      step(1);
      i_req = '0;
      step(1);
      check("mid_code", o_code, 7);
      rst = 1'b1;
      #2;
      check("mid_rst_valid", o_valid, 0);
      step(1);
      rst      = 1'b0;
      i_ready  = 1'b1;
      xfer_log.delete();
      step(10);
      check("mid_no_codes", xfer_log.size(), 0);

      // Random traffic against the model
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 3) == 0) i_req = N'($urandom);
         else if ($urandom_range(0, 2) == 0) i_req = '0;
         i_ready = ($urandom_range(0, 3) != 0);
         step(1);
      end
      i_req   = '0;
      i_ready = 1'b1;
      step(20);
      check("final_valid", o_valid, 0);
      check("final_code_q", code_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
